// File: rtl/fetch_cycle.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to instruction
// memory and buffers returned {PC, instruction} pairs for decode.
module fetch_cycle #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned     BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] PC_out,
    input  logic            decode_ready
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned WW = XLEN - 2;

    logic            started_q, started_d;
    logic [WW-1:0]   fetch_word_q, fetch_word_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [XLEN-1:0] buf_instr_q [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc_q    [BUF_DEPTH];
    logic [XLEN-1:0] tag_q       [BUF_DEPTH];

    logic [SW-1:0]   occupancy;
    logic            req_fire, resp_ok, resp_keep, push, pop;
    logic            unused_redirect_lsb;

    // Fetch PC is held as a word address, so redirect low bits are simply dropped.
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // In-flight requests count against buffer space so a response always has a slot.
    assign occupancy      = SW'(inflight_q) + SW'(count_q);
    assign imem_req_valid = started_q & ~redirect_valid & (occupancy < SW'(BUF_DEPTH));
    assign imem_req_addr  = {fetch_word_q, 2'b00};

    assign req_fire  = imem_req_valid & imem_req_ready;
    assign resp_ok   = imem_resp_valid & (inflight_q != '0);
    assign resp_keep = resp_ok & (drop_q == '0);
    assign push      = resp_keep & ~redirect_valid;
    assign pop       = instr_valid & decode_ready & ~redirect_valid;

    assign instr_valid = (count_q != '0);
    assign instruction = instr_valid ? buf_instr_q[rd_ptr_q] : '0;
    assign PC_out      = instr_valid ? buf_pc_q[rd_ptr_q] : '0;

    always_comb begin
        started_d    = 1'b1;
        fetch_word_d = fetch_word_q;
        inflight_d   = inflight_q + CW'(req_fire) - CW'(resp_ok);
        drop_d       = drop_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        tag_rd_d     = tag_rd_q;
        tag_wr_d     = tag_wr_q;

        if (redirect_valid) begin
            // Everything still outstanding, minus a response landing now, is stale.
            fetch_word_d = redirect_pc[XLEN-1:2];
            drop_d       = inflight_q - CW'(resp_ok);
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            tag_rd_d     = '0;
            tag_wr_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_word_d = fetch_word_q + WW'(1);
                tag_wr_d     = tag_wr_q + AW'(1);
            end
            if (resp_ok && drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end
            if (resp_keep) begin
                tag_rd_d = tag_rd_q + AW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            started_q    <= 1'b0;
            fetch_word_q <= RESET_PC[XLEN-1:2];
            inflight_q   <= '0;
            drop_q       <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            tag_rd_q     <= '0;
            tag_wr_q     <= '0;
        end else begin
            started_q    <= started_d;
            fetch_word_q <= fetch_word_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            tag_rd_q     <= tag_rd_d;
            tag_wr_q     <= tag_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr_q] <= imem_req_addr;
        end
        if (push) begin
            buf_instr_q[wr_ptr_q] <= imem_resp_data;
            buf_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
        end
    end

`ifndef SYNTHESIS
    resp_without_request: assert property (
        @(posedge clk) disable iff (!rst) !(imem_resp_valid && inflight_q == '0)
    );
`endif

endmodule

// File: tb/tb_fetch_cycle.sv
// Randomized bench for fetch_cycle: an in-order memory and a queue-based model of
// outstanding requests and the decode-side buffer predict every output each cycle.
module tb_fetch_cycle;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_v, ready, resp_v, redir, iv, dec_rdy;
    logic [31:0] req_addr, resp_data, redir_pc, instr, pco;

    always #5 clk = ~clk;

    fetch_cycle #(.XLEN(32), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req_v),
        .imem_req_ready (ready),
        .imem_req_addr  (req_addr),
        .imem_resp_valid(resp_v),
        .imem_resp_data (resp_data),
        .redirect_valid (redir),
        .redirect_pc    (redir_pc),
        .instr_valid    (iv),
        .instruction    (instr),
        .PC_out         (pco),
        .decode_ready   (dec_rdy)
    );

    typedef struct { logic [31:0] pc; logic [31:0] d; } ent_t;
    typedef struct { logic [31:0] a; int due; bit stale; } req_t;

    int          tests = 0, fails = 0, cyc = 0;
    bit          m_started;
    logic [31:0] m_fpc, exp_next_pc;
    ent_t        m_buf[$];
    req_t        m_out[$];
    logic [31:0] acc_log[$], cons_log[$];

    int          p_ready = 100, p_dec = 100, p_redir = 0, lat_min = 1, lat_max = 1;
    bit          tog = 0, mem_hold = 0, force_redir = 0;
    logic [31:0] force_pc = '0;

    bit          last_rv, last_iv;
    logic [31:0] last_addr, last_instr, last_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_note(input string name);
        tests++;
        fails++;
        $display("FAIL %s: condition not reached within cycle budget (cycle %0d)", name, cyc);
    endtask

    task automatic reset_model();
        m_buf.delete();
        m_out.delete();
        m_started   = 1'b0;
        m_fpc       = RST_PC;
        exp_next_pc = RST_PC;
    endtask

    task automatic drive_inputs();
        ready     = tog ? ((cyc % 2) == 1) : ($urandom_range(0, 99) < p_ready);
        dec_rdy   = $urandom_range(0, 99) < p_dec;
        redir     = rst && (force_redir || ($urandom_range(0, 99) < p_redir));
        redir_pc  = force_redir ? force_pc : $urandom;
        resp_v    = rst && !mem_hold && m_out.size() > 0 && m_out[0].due <= cyc;
        resp_data = resp_v ? memf(m_out[0].a) : $urandom;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit          e_rv, e_iv, cons, acc;
        logic [31:0] e_instr, e_pc;
        req_t        r;
        int          lat;
        @(negedge clk);
        e_rv    = rst && m_started && !redir && (m_out.size() + m_buf.size() < DEPTH);
        e_iv    = m_buf.size() > 0;
        e_instr = e_iv ? m_buf[0].d : 32'h0;
        e_pc    = e_iv ? m_buf[0].pc : 32'h0;
        chk("req_valid", 32'(req_v), 32'(e_rv));
        if (e_rv) chk("req_addr", req_addr, m_fpc);
        chk("instr_valid", 32'(iv), 32'(e_iv));
        chk("instruction", instr, e_instr);
        chk("pc_out", pco, e_pc);
        last_rv = req_v; last_iv = iv; last_addr = req_addr; last_instr = instr; last_pc = pco;
        if (req_v && ready) acc_log.push_back(req_addr);
        if (iv && dec_rdy && !redir) cons_log.push_back(pco);
        cons = e_iv && dec_rdy && !redir;
        if (cons) begin
            chk("seq_pc", pco, exp_next_pc);
            chk("seq_data", instr, memf(exp_next_pc));
            exp_next_pc += 32'd4;
        end
        acc = e_rv && ready;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            reset_model();
        end else begin
            if (cons) void'(m_buf.pop_front());
            if (resp_v) begin
                r = m_out.pop_front();
                if (!r.stale && !redir) m_buf.push_back('{r.a, memf(r.a)});
            end
            if (redir) begin
                m_buf.delete();
                foreach (m_out[i]) m_out[i].stale = 1'b1;
                m_fpc       = {redir_pc[31:2], 2'b00};
                exp_next_pc = m_fpc;
            end else if (acc) begin
                lat = int'($urandom_range(lat_max, lat_min));
                m_out.push_back('{m_fpc, cyc + lat - 1, 1'b0});
                m_fpc += 32'd4;
            end
            m_started = 1'b1;
        end
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        force_redir = 1'b0;
        mem_hold    = 1'b0;
        reset_model();
        drive_inputs();
        cycle();
        cycle();
    endtask

    task automatic release_rst();
        rst = 1'b1;
        drive_inputs();
    endtask

    // Leaves two requests outstanding and one instruction buffered.
    task automatic setup_split();
        bit ok = 1'b0;
        mem_hold = 1'b1; p_ready = 100; p_dec = 0; lat_min = 1; lat_max = 1;
        release_rst();
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (m_out.size() == 3) begin ok = 1'b1; break; end
        end
        if (!ok) fail_note("setup_inflight");
        p_ready = 0; mem_hold = 1'b0;
        drive_inputs();
        cycle();
        mem_hold = 1'b1;
        drive_inputs();
    endtask

    task automatic wait_iv(input logic [31:0] exp, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_iv) begin chk(name, last_pc, exp); found = 1'b1; break; end
        end
        if (!found) fail_note(name);
    endtask

    initial begin
        int          first_req, first_iv;
        logic [31:0] f_addr, f_pc, f_instr;
        bit          ok;

        ready = 0; resp_v = 0; redir = 0; dec_rdy = 0;
        resp_data = '0; redir_pc = '0;
        reset_model();
        @(posedge clk);
        #1;
        drive_inputs();
        cycle();
        cycle();
        chk("reset_req_valid", 32'(last_rv), 32'h0);
        chk("reset_instr_valid", 32'(last_iv), 32'h0);
        chk("reset_instruction", last_instr, 32'h0);
        chk("reset_pc_out", last_pc, 32'h0);

        // Streaming start-up and throughput
        release_rst();
        first_req = -1; first_iv = -1;
        f_addr = '1; f_pc = '1; f_instr = '1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_rv && first_req < 0) begin first_req = i; f_addr = last_addr; end
            if (last_iv && first_iv < 0) begin first_iv = i; f_pc = last_pc; f_instr = last_instr; end
        end
        chk("first_req_cycle", 32'(first_req), 32'd1);
        chk("first_req_addr", f_addr, 32'h0);
        chk("first_iv_cycle", 32'(first_iv), 32'd3);
        chk("first_pc", f_pc, 32'h0);
        chk("first_instr", f_instr, 32'hA5A5_0000);
        cons_log.delete();
        repeat (20) cycle();
        chk("throughput", 32'(cons_log.size()), 32'd20);

        // Decode stall fills the buffer, then drains in order
        do_reset();
        p_dec = 0;
        acc_log.delete();
        release_rst();
        repeat (10) cycle();
        chk("stall_req_count", 32'(acc_log.size()), 32'd4);
        chk("stall_req_valid", 32'(last_rv), 32'h0);
        chk("stall_head_pc", last_pc, 32'h0);
        p_dec = 100;
        cons_log.delete();
        drive_inputs();
        repeat (8) cycle();
        if (cons_log.size() >= 4) begin
            chk("drain_pc0", cons_log[0], 32'h0);
            chk("drain_pc1", cons_log[1], 32'h4);
            chk("drain_pc2", cons_log[2], 32'h8);
            chk("drain_pc3", cons_log[3], 32'hC);
        end else fail_note("drain_count");

        // Toggling ready with 3-cycle memory latency
        tog = 1'b1; lat_min = 3; lat_max = 3; p_dec = 70;
        drive_inputs();
        repeat (80) cycle();
        tog = 1'b0; lat_min = 1; lat_max = 1; p_dec = 100;

        // Redirect with two requests in flight and one buffered
        do_reset();
        setup_split();
        force_redir = 1'b1; force_pc = 32'h0000_0103;
        drive_inputs();
        cycle();
        chk("redir_cycle_req_valid", 32'(last_rv), 32'h0);
        chk("redir_cycle_buffered", 32'(last_iv), 32'h1);
        force_redir = 1'b0; p_ready = 100; p_dec = 100; mem_hold = 1'b0;
        drive_inputs();
        cycle();
        chk("redir_req_valid", 32'(last_rv), 32'h1);
        chk("redir_req_addr", last_addr, 32'h0000_0100);
        chk("redir_flushed", 32'(last_iv), 32'h0);
        wait_iv(32'h0000_0100, "redir_first_pc");

        // Redirect coinciding with a response and decode_ready
        do_reset();
        setup_split();
        mem_hold = 1'b0; p_dec = 100; force_redir = 1'b1; force_pc = 32'h0000_0200;
        drive_inputs();
        cycle();
        force_redir = 1'b0; p_ready = 100;
        drive_inputs();
        cycle();
        chk("coincide_flushed", 32'(last_iv), 32'h0);
        chk("coincide_req_addr", last_addr, 32'h0000_0200);
        wait_iv(32'h0000_0200, "coincide_first_pc");

        // Reset asserted mid-stream with three requests outstanding
        do_reset();
        mem_hold = 1'b1; p_ready = 100; p_dec = 0;
        release_rst();
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (m_out.size() == 3) begin ok = 1'b1; break; end
        end
        if (!ok) fail_note("midrst_setup");
        rst = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(req_v), 32'h0);
        chk("midrst_instr_valid", 32'(iv), 32'h0);
        chk("midrst_instruction", instr, 32'h0);
        chk("midrst_pc_out", pco, 32'h0);
        reset_model();
        mem_hold = 1'b0;
        drive_inputs();
        cycle();
        cycle();
        p_dec = 100;
        release_rst();
        ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (last_rv) begin chk("midrst_restart_addr", last_addr, RST_PC); ok = 1'b1; break; end
        end
        if (!ok) fail_note("midrst_restart");

        // Fetch PC wraps past the top of the address space
        force_redir = 1'b1; force_pc = 32'hFFFF_FFF8;
        drive_inputs();
        cycle();
        force_redir = 1'b0;
        acc_log.delete();
        drive_inputs();
        repeat (5) cycle();
        if (acc_log.size() >= 3) begin
            chk("wrap_addr0", acc_log[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", acc_log[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", acc_log[2], 32'h0000_0000);
        end else fail_note("wrap_count");

        // Random soak
        p_ready = 70; p_dec = 70; p_redir = 3; lat_min = 1; lat_max = 4;
        drive_inputs();
        repeat (1500) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
